// File: rtl/mult4_ex_unit.sv
// Four-cycle iterative multiplier for the EX stage: consumes one quarter of the
// multiplier per cycle and hands a registered low-half product to EX/MEM.
module mult4_ex_unit #(
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              arst,
    input  logic              mult_start,
    input  logic              flush,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    input  logic [4:0]        rd_in,
    output logic              stall,
    output logic              mult_done,
    output logic [DATA_W-1:0] mult_result,
    output logic [4:0]        mult_rd,
    output logic              mult_reg_write
);
    localparam int SLICE_W = DATA_W / 4;
    localparam int SH_W    = $clog2(DATA_W);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state_q, state_d;
    logic [1:0]         cnt_q, cnt_d;
    logic [DATA_W-1:0]  acc_q, acc_d;
    logic [DATA_W-1:0]  a_q, a_d;
    logic [DATA_W-1:0]  b_q, b_d;
    logic [4:0]         rd_lat_q, rd_lat_d;
    logic [DATA_W-1:0]  result_q, result_d;
    logic [4:0]         rd_q, rd_d;

    logic [SLICE_W-1:0] slice;
    logic [DATA_W-1:0]  pp;
    logic [SH_W-1:0]    shamt;
    logic               accept;

    // Unsigned slices: the truncated sum is the low half of either signed or unsigned product.
    always_comb begin
        slice = b_q[cnt_q*SLICE_W +: SLICE_W];
        pp    = a_q * DATA_W'(slice);
        shamt = SH_W'(cnt_q) * SH_W'(SLICE_W);
    end

    assign accept = (state_q == IDLE) && mult_start && !flush;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        a_d      = a_q;
        b_d      = b_q;
        rd_lat_d = rd_lat_q;
        result_d = result_q;
        rd_d     = rd_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    a_d      = op_a;
                    b_d      = op_b;
                    rd_lat_d = rd_in;
                    acc_d    = '0;
                    cnt_d    = 2'd0;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    acc_d = acc_q + (pp << shamt);
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        // Publish on the last slice so result/rd only change when done pulses.
                        result_d = acc_d;
                        rd_d     = rd_lat_q;
                        state_d  = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            rd_lat_q <= '0;
            result_q <= '0;
            rd_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            a_q      <= a_d;
            b_q      <= b_d;
            rd_lat_q <= rd_lat_d;
            result_q <= result_d;
            rd_q     <= rd_d;
        end
    end

    // Reset forces stall low even if a held start would otherwise assert it.
    assign stall          = !arst && (accept || (state_q == BUSY));
    assign mult_done      = (state_q == DONE);
    assign mult_result    = result_q;
    assign mult_rd        = rd_q;
    assign mult_reg_write = mult_done && (rd_q != 5'd0);

endmodule

// File: doc/mult4_ex_unit.md
# mult4_ex_unit

Four-cycle iterative integer multiplier in the EX stage of the five-stage pipeline.
- Consumes operands after the EX forwarding muxes, so forwarded values are already resolved.
- Freezes the front of the pipeline while it computes.
- Hands a registered product, destination register and write-enable to the EX/MEM boundary.
- The forwarding logic sees these as the EX/MEM destination and write-enable.

## Interface
Parameters:
- DATA_W, 64, operand/result width; must be a multiple of 4
- SLICE_W, DATA_W/4, multiplier-operand bits consumed per compute cycle (derived, not overridable)

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  pipeline clock, rising edge
- arst  in  1  asynchronous active-high reset
- mult_start  in  1  MUL instruction present in EX, valid
- flush  in  1  kill the instruction in EX (branch mispredict / exception)
- op_a  in  DATA_W  multiplicand, post-forwarding
- op_b  in  DATA_W  multiplier, post-forwarding
- rd_in  in  5  destination register of the MUL
- stall  out  1  freeze PC, IF/ID and ID/EX; hold EX
- mult_done  out  1  one-cycle pulse: product valid this cycle
- mult_result  out  DATA_W  product, low DATA_W bits
- mult_rd  out  5  destination register for the product
- mult_reg_write  out  1  write-enable for EX/MEM; equals mult_done && (mult_rd != 0)

## Operation
FSM states are IDLE, BUSY and DONE. A 2-bit slice counter cnt and an accumulator acc (DATA_W) are used.

IDLE:
- On mult_start && !flush:
  - latch op_a, op_b and rd_in;
  - set acc = 0 and cnt = 0;
  - go to BUSY.
- Otherwise stay in IDLE.

BUSY:
- Each cycle: acc <= acc + ((a_q * b_q[cnt*SLICE_W +: SLICE_W]) << (cnt*SLICE_W)), truncated to DATA_W.
- Slices of b_q are treated as unsigned. The truncated sum equals the low DATA_W bits of the signed or unsigned product, which is RV MUL semantics.
- cnt increments each cycle. When cnt == 3, go to DONE after the update.

DONE:
- mult_done = 1 and mult_result = acc.
- Go to IDLE unconditionally.

Control rules:
- mult_start is ignored in BUSY and DONE. The frozen instruction keeps start high and must not retrigger.
- flush in IDLE suppresses acceptance.
- flush in BUSY aborts to IDLE with no mult_done.
- flush in DONE has no effect; the result is already committed to EX/MEM.
- mult_result and mult_rd hold their last values outside DONE. Consumers qualify them with mult_done.

Reset (arst, at any time including mid-operation):
- State goes to IDLE; cnt, acc, latched operands and mult_rd go to 0.
- Outputs: stall = 0, mult_done = 0, mult_result = 0, mult_rd = 0, mult_reg_write = 0.

## Timing
Start at cycle T (state IDLE, mult_start = 1, flush = 0):
- Cycle T: stall = 1, combinational from mult_start in IDLE. Operands are latched at the end of T.
- Cycles T+1..T+4: BUSY with cnt = 0..3; stall = 1.
- Cycle T+5: DONE; stall = 0; mult_done = 1; mult_result and mult_rd valid. The pipeline advances at the end of T+5.

Totals:
- Issue-to-result latency is 5 cycles; the front end is frozen for 5 cycles (T..T+4).
- The back-to-back minimum is a second mult_start accepted at T+6. The repeat period is 6 cycles.

Other timing rules:
- stall is combinational only via the IDLE && mult_start && !flush term. All other outputs are registered.
- Flush at cycle F during BUSY: stall is still 1 in cycle F, state is IDLE at F+1, and mult_done never pulses.

## Test plan
- Basic product: op_a = 3, op_b = 5, rd_in = 7, mult_start held from T → stall high T..T+4; at T+5 mult_done = 1, mult_result = 15, mult_rd = 7, mult_reg_write = 1, stall = 0.
- Truncation and sign: op_a = 0xFFFF_FFFF_FFFF_FFFF, op_b = 2 → mult_result = 0xFFFF_FFFF_FFFF_FFFE at T+5. Also op_a = 0x1_0000_0000, op_b = 0x1_0000_0000 → mult_result = 0.
- Cross-slice: op_a = 0x0000_0000_0001_0001, op_b = 0x0001_0000_0000_0001 → mult_result = 0x0001_0000_0001_0001.
- Back-to-back: MUL (2×9, rd = 3) followed by MUL (4×4, rd = 4) → done pulses at T+5 (result 18, rd 3) and T+11 (result 16, rd 4). There is no retrigger while start is held during T+1..T+5.
- Flush mid-operation: start at T, flush = 1 at T+2 → stall = 1 at T+2, stall = 0 from T+3, no mult_done. A new start at T+3 completes normally at T+8.
- Reset and rd = 0: arst pulse at T+3 → immediately stall = 0 and all outputs 0; the FSM restarts cleanly on the next start. A MUL with rd_in = 0 → mult_done = 1 and mult_reg_write = 0 at T+5.
